// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, consumer handshake and received byte out.
// frm_err exists only when UART_RX_FRAME_ERR_EN is defined.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frm_err;

    modport master (output RX, output clr_rdy, input rx_data, input rdy, input frm_err);
    modport slave  (input RX, input clr_rdy, output rx_data, output rdy, output frm_err);
`else
    modport master (output RX, output clr_rdy, input rx_data, input rdy);
    modport slave  (input RX, input clr_rdy, output rx_data, output rdy);
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver with sticky rdy flag.
// Optional stop-bit checking (frm_err output) when UART_RX_FRAME_ERR_EN is defined.
module uart_rx #(
    parameter int BAUD_CNT = 2604,
    parameter int HALF_CNT = BAUD_CNT / 2
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int              CNT_W    = $clog2(BAUD_CNT);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_CNT);
    localparam logic [CNT_W-1:0] BAUD_LD = CNT_W'(BAUD_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [3:0]       LAST_BIT = 4'd9;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic             sync1_r, sync2_r, prev_r;
    logic             fall_s;
    logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [3:0]       bit_cnt_r, bit_cnt_s;
    logic [8:0]       shift_r, shift_s;
    logic             rdy_r, rdy_s;
`ifdef UART_RX_FRAME_ERR_EN
    logic             frm_err_r, frm_err_s;

    assign bus.frm_err = frm_err_r;
`endif

    // Start bit is detected as a 1->0 step of the synchronized line.
    assign fall_s      = prev_r & ~sync2_r;
    assign bus.rx_data = shift_r[7:0];
    assign bus.rdy     = rdy_r;

    // Two-flop synchronizer plus history flop; preset high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= bus.RX;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 9'd0;
            rdy_r      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frm_err_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            rdy_r      <= rdy_s;
`ifdef UART_RX_FRAME_ERR_EN
            frm_err_r  <= frm_err_s;
`endif
        end
    end

    // Next-state logic; frame-end set is evaluated after clr_rdy so a simultaneous set wins.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        rdy_s      = rdy_r;
`ifdef UART_RX_FRAME_ERR_EN
        frm_err_s  = frm_err_r;
`endif

        if (bus.clr_rdy) begin
            rdy_s = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frm_err_s = 1'b0;
`endif
        end else begin
            rdy_s = rdy_r;
        end

        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    state_s    = RECEIVE;
                    baud_cnt_s = HALF_LD;
                    bit_cnt_s  = 4'd0;
                    rdy_s      = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                    frm_err_s  = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RECEIVE: begin
                if (baud_cnt_r == CNT_ZERO) begin
                    shift_s    = {sync2_r, shift_r[8:1]};
                    bit_cnt_s  = bit_cnt_r + 4'd1;
                    baud_cnt_s = BAUD_LD;
                    // Tenth sample is the stop bit; the start bit has already shifted out.
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                        if (sync2_r) begin
                            rdy_s = 1'b1;
                        end else begin
                            frm_err_s = 1'b1;
                        end
`else
                        rdy_s = 1'b1;
`endif
                    end else begin
                        state_s = RECEIVE;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-bangs 8N1 frames and checks rdy/rx_data against timing windows.
module tb_uart_rx;
    localparam int B   = 16;
    localparam int H   = 8;
    localparam int BIG = 1000000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    uart_rx_if bus ();

    uart_rx #(.BAUD_CNT(B), .HALF_CNT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    // Model: rdy must be low in [lo_from,lo_to], high with rx_data==exp_data in [hi_from,hi_to].
    int lo_from = 0;
    int lo_to   = BIG;
    int hi_from = BIG;
    int hi_to   = -1;
    logic [7:0] exp_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %02h, expected %02h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= lo_from && cyc <= lo_to) check("rdy_low", {7'd0, bus.rdy}, 8'h00);
        if (cyc >= hi_from && cyc <= hi_to) begin
            check("rdy_high", {7'd0, bus.rdy}, 8'h01);
            check("rx_data", bus.rx_data, exp_data);
        end
    end

    // Frame starts right after a rising edge; rdy is expected about 9*B+H+4 clocks later.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ok,
                              input int nbits, input logic clr_hold);
        logic [9:0] bits;
        int c0;
        bits = {stop, d, 1'b0};
        @(posedge clk); #1;
        c0       = cyc;
        hi_to    = ok ? BIG : c0 - 1;
        hi_from  = ok ? c0 + 9*B + H + 6 : BIG;
        lo_from  = c0 + 5;
        lo_to    = ok ? c0 + 9*B + H + 1 : BIG;
        exp_data = d;
        for (int i = 0; i < nbits; i++) begin
            bus.RX = bits[i];
            if (i == 9 && clr_hold) bus.clr_rdy = 1'b1;
            for (int k = 0; k < B; k++) begin
                @(posedge clk); #1;
                if (bus.clr_rdy && bus.rdy) bus.clr_rdy = 1'b0;
            end
        end
        if (clr_hold) check("clr_hold_timeout", {7'd0, bus.clr_rdy}, 8'h00);
        bus.clr_rdy = 1'b0;
        bus.RX      = 1'b1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        bus.clr_rdy = 1'b1;
        hi_to   = cyc;
        lo_from = cyc + 1;
        lo_to   = BIG;
        @(posedge clk); #1;
        bus.clr_rdy = 1'b0;
        check("clr_next_clock", {7'd0, bus.rdy}, 8'h00);
    endtask

    initial begin
        bus.RX      = 1'b1;
        bus.clr_rdy = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", {7'd0, bus.rdy}, 8'h00);
        check("reset_data", bus.rx_data, 8'h00);
        rst = 1'b0;

        send_frame(8'hD3, 1'b1, 1'b1, 10, 1'b0);
        check("d3_rdy", {7'd0, bus.rdy}, 8'h01);
        check("d3_data", bus.rx_data, 8'hD3);
        pulse_clr();

        send_frame(8'h00, 1'b1, 1'b1, 10, 1'b0);
        check("b2b_00_data", bus.rx_data, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b1, 10, 1'b0);
        check("b2b_ff_rdy", {7'd0, bus.rdy}, 8'h01);
        check("b2b_ff_data", bus.rx_data, 8'hFF);

        send_frame(8'hA5, 1'b1, 1'b1, 10, 1'b1);
        check("a5_set_wins", {7'd0, bus.rdy}, 8'h01);
        check("a5_data", bus.rx_data, 8'hA5);
        pulse_clr();

        send_frame(8'h3C, 1'b1, 1'b0, 5, 1'b0);
        rst     = 1'b1;
        lo_from = cyc;
        lo_to   = BIG;
        hi_from = BIG;
        #1;
        check("midrst_rdy", {7'd0, bus.rdy}, 8'h00);
        check("midrst_data", bus.rx_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20*B) @(posedge clk);
        #1;
        check("idle_rdy", {7'd0, bus.rdy}, 8'h00);
        check("idle_data", bus.rx_data, 8'h00);

        send_frame(8'h5A, 1'b1, 1'b1, 10, 1'b0);
        check("5a_data", bus.rx_data, 8'h5A);
        pulse_clr();

`ifdef UART_RX_FRAME_ERR_EN
        send_frame(8'h81, 1'b0, 1'b0, 10, 1'b0);
        check("ferr_set", {7'd0, bus.frm_err}, 8'h01);
        check("ferr_rdy", {7'd0, bus.rdy}, 8'h00);
        check("ferr_data", bus.rx_data, 8'h81);
        send_frame(8'h81, 1'b1, 1'b1, 10, 1'b0);
        check("ferr_clear", {7'd0, bus.frm_err}, 8'h00);
        check("ok81_rdy", {7'd0, bus.rdy}, 8'h01);
        check("ok81_data", bus.rx_data, 8'h81);
`else
        send_frame(8'h81, 1'b0, 1'b1, 10, 1'b0);
        check("badstop_rdy", {7'd0, bus.rdy}, 8'h01);
        check("badstop_data", bus.rx_data, 8'h81);
`endif

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
